vga_plot_sink: RTL and testbench

- Receiving end of the VGA pixel-plot interface. Accepts the same VGA_X / VGA_Y / VGA_COLOR / plot stream that a vga_demo-style producer drives.
- Buffers plot commands in a small FIFO, clips off-screen coordinates, and converts each accepted pixel into a linear frame-buffer write with a valid/ready handshake.
- Sits between the pixel producer and the frame-buffer memory; provides drop and clip counters for debug on LEDR/HEX.

---
 rtl/vga_plot_sink.sv | 171 +++++++++++++++++
 tb/tb_vga_plot_sink.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// Receiving end of the VGA pixel-plot stream: buffers plot commands, clips off-screen
// pixels and turns each accepted pixel into a linear frame-buffer write (valid/ready).
module vga_plot_sink #(
    parameter int XRES  = 320,
    parameter int YRES  = 240,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 17
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [XW-1:0]            VGA_X,
    input  logic [YW-1:0]            VGA_Y,
    input  logic [23:0]              VGA_COLOR,
    input  logic                     plot,
    output logic [AW-1:0]            fb_addr,
    output logic [23:0]              fb_data,
    output logic                     fb_we,
    input  logic                     fb_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              clip_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = XW + YW + 24;
    localparam logic [XW:0]   X_LIM   = (XW+1)'(XRES);
    localparam logic [YW:0]   Y_LIM   = (YW+1)'(YRES);
    localparam logic [PW:0]   LVL_MAX = (PW+1)'(DEPTH);
    localparam logic [PW:0]   LVL_ONE = (PW+1)'(1);
    localparam logic [15:0]   CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WRITE = 2'd2} state_t;

    state_t             state_r, next_state_s;
    logic [EW-1:0]      mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PW:0]        count_r, count_next_s;
    logic [XW-1:0]      hold_x_r;
    logic [YW-1:0]      hold_y_r;
    logic [23:0]        hold_color_r;
    logic [AW-1:0]      fb_addr_r;
    logic [23:0]        fb_data_r;
    logic               fb_we_r, busy_r;
    logic [15:0]        drop_cnt_r, clip_cnt_r;
    logic               in_range_s, full_s, empty_s, done_s;
    logic               push_s, pop_s, load_addr_s, clip_inc_s, drop_inc_s;
    logic [EW-1:0]      head_s;

    assign in_range_s = ({1'b0, VGA_X} < X_LIM) && ({1'b0, VGA_Y} < Y_LIM);
    assign full_s     = (count_r == LVL_MAX);
    assign empty_s    = (count_r == {(PW+1){1'b0}});
    assign done_s     = (state_r == WRITE) && fb_we_r && fb_ready;
    assign push_s     = plot && in_range_s && (!full_s || pop_s);
    assign clip_inc_s = plot && !in_range_s;
    assign drop_inc_s = plot && in_range_s && full_s && !pop_s;
    assign head_s     = mem_r[rd_ptr_r];

    // FIFO occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + LVL_ONE;
            2'b01:   count_next_s = count_r - LVL_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) next_state_s = ADDR;
                else          next_state_s = IDLE;
            end
            ADDR:  next_state_s = WRITE;
            WRITE: begin
                if (done_s) next_state_s = empty_s ? IDLE : ADDR;
                else        next_state_s = WRITE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM control outputs: pop when idle with data, or straight after a completed write
    always_comb begin
        pop_s       = 1'b0;
        load_addr_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = !empty_s;
            ADDR:    load_addr_s = 1'b1;
            WRITE:   pop_s = done_s && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {VGA_X, VGA_Y, VGA_COLOR};
        end
    end

    // FIFO pointers, level and the holding registers fed by a pop
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {(PW+1){1'b0}};
            hold_x_r     <= {XW{1'b0}};
            hold_y_r     <= {YW{1'b0}};
            hold_color_r <= 24'h000000;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            if (pop_s) begin
                rd_ptr_r                           <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                {hold_x_r, hold_y_r, hold_color_r} <= head_s;
            end
            count_r <= count_next_s;
        end
    end

    // Registered frame-buffer port and busy flag
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            fb_addr_r <= {AW{1'b0}};
            fb_data_r <= 24'h000000;
            fb_we_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (load_addr_s) begin
                fb_addr_r <= AW'(hold_y_r) * AW'(XRES) + AW'(hold_x_r);
                fb_data_r <= hold_color_r;
            end
            fb_we_r <= (next_state_s == WRITE);
            busy_r  <= (count_next_s != {(PW+1){1'b0}}) || (next_state_s != IDLE);
        end
    end

    // Saturating debug counters
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            drop_cnt_r <= 16'h0000;
            clip_cnt_r <= 16'h0000;
        end else begin
            if (drop_inc_s && (drop_cnt_r != CNT_MAX)) drop_cnt_r <= drop_cnt_r + 16'h0001;
            if (clip_inc_s && (clip_cnt_r != CNT_MAX)) clip_cnt_r <= clip_cnt_r + 16'h0001;
        end
    end

    assign fb_addr    = fb_addr_r;
    assign fb_data    = fb_data_r;
    assign fb_we      = fb_we_r;
    assign fifo_level = count_r;
    assign busy       = busy_r;
    assign drop_cnt   = drop_cnt_r;
    assign clip_cnt   = clip_cnt_r;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed testbench for vga_plot_sink: hand-computed expectations checked per scenario.
module tb_vga_plot_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [23:0] vga_color;
    logic        plot;
    logic        fb_ready;
    logic [16:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_we;
    logic [3:0]  fifo_level;
    logic        busy;
    logic [15:0] drop_cnt;
    logic [15:0] clip_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_plot_sink dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .VGA_X      (vga_x),
        .VGA_Y      (vga_y),
        .VGA_COLOR  (vga_color),
        .plot       (plot),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .clip_cnt   (clip_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; plot = 1'b0; fb_ready = 1'b0;
        vga_x = 9'd0; vga_y = 8'd0; vga_color = 24'h000000;
        repeat (3) tick();
        n_cmp++; if (fb_we !== 1'b0)       begin n_err++; $display("FAIL reset_we got=%0b exp=0", fb_we); end
        n_cmp++; if (fifo_level !== 4'd0)  begin n_err++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (fb_addr !== 17'd0)    begin n_err++; $display("FAIL reset_addr got=%0d exp=0", fb_addr); end
        n_cmp++; if ({drop_cnt, clip_cnt} !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", {drop_cnt, clip_cnt}); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        fb_ready = 1'b1;
        vga_x = 9'd5; vga_y = 8'd2; vga_color = 24'hFF8000; plot = 1'b1;
        tick();  // E0: sampled
        plot = 1'b0;
        n_cmp++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        n_cmp++; if (busy !== 1'b1)       begin n_err++; $display("FAIL single_busy got=%0b exp=1", busy); end
        tick();  // E1
        n_cmp++; if (fb_we !== 1'b0)      begin n_err++; $display("FAIL single_we_e1 got=%0b exp=0", fb_we); end
        tick();  // E2
        n_cmp++; if (fb_we !== 1'b1)      begin n_err++; $display("FAIL single_we_e2 got=%0b exp=1", fb_we); end
        n_cmp++; if (fb_addr !== 17'd645) begin n_err++; $display("FAIL single_addr got=%0d exp=645", fb_addr); end
        n_cmp++; if (fb_data !== 24'hFF8000) begin n_err++; $display("FAIL single_data got=%h exp=ff8000", fb_data); end
        tick();  // E3: write completes
        n_cmp++; if (fb_we !== 1'b0)      begin n_err++; $display("FAIL single_we_e3 got=%0b exp=0", fb_we); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL single_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_clip();
        int we_seen = 0;
        fb_ready = 1'b1;
        vga_x = 9'd320; vga_y = 8'd0;   vga_color = 24'h111111; plot = 1'b1; tick();
        vga_x = 9'd0;   vga_y = 8'd240; vga_color = 24'h222222; tick();
        plot = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fb_we || fifo_level != 4'd0) we_seen++;
            tick();
        end
        n_cmp++; if (clip_cnt !== 16'd2) begin n_err++; $display("FAIL clip_cnt got=%0d exp=2", clip_cnt); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL clip_drop got=%0d exp=0", drop_cnt); end
        n_cmp++; if (we_seen !== 0)      begin n_err++; $display("FAIL clip_activity got=%0d exp=0", we_seen); end
        // last on-screen pixel is accepted
        vga_x = 9'd319; vga_y = 8'd239; vga_color = 24'h0000FF; plot = 1'b1; tick();
        plot = 1'b0; tick(); tick();
        n_cmp++; if (fb_we !== 1'b1)        begin n_err++; $display("FAIL corner_we got=%0b exp=1", fb_we); end
        n_cmp++; if (fb_addr !== 17'd76799) begin n_err++; $display("FAIL corner_addr got=%0d exp=76799", fb_addr); end
        n_cmp++; if (clip_cnt !== 16'd2)    begin n_err++; $display("FAIL corner_clip got=%0d exp=2", clip_cnt); end
        tick();
    endtask

    // Ten back-to-back pixels with the memory stalled: p0 moves into the write stage,
    // p1..p8 fill the FIFO, p9 is dropped.
    task automatic test_overflow();
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vga_x = 9'(i); vga_y = 8'd0; vga_color = 24'hA00000 + 24'(i); plot = 1'b1;
            tick();
        end
        plot = 1'b0;
        n_cmp++; if (fifo_level !== 4'd8)  begin n_err++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
        n_cmp++; if (drop_cnt !== 16'd1)   begin n_err++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); end
        n_cmp++; if (fb_we !== 1'b1)       begin n_err++; $display("FAIL ovf_we got=%0b exp=1", fb_we); end
        n_cmp++; if (fb_addr !== 17'd0)    begin n_err++; $display("FAIL ovf_addr got=%0d exp=0", fb_addr); end
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fb_we !== 1'b1 || fb_addr !== 17'd0 || fb_data !== 24'hA00000) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
    endtask

    task automatic test_full_pop();
        logic [16:0] exp_addr [9];
        logic [23:0] exp_data [9];
        int got = 0;
        for (int i = 0; i < 8; i++) begin
            exp_addr[i] = 17'(i + 1);
            exp_data[i] = 24'hA00000 + 24'(i + 1);
        end
        exp_addr[8] = 17'd1060;  // 3*320 + 100
        exp_data[8] = 24'h123456;
        // write of p0 completes on the same edge the new pixel arrives at a full FIFO
        fb_ready = 1'b1;
        vga_x = 9'd100; vga_y = 8'd3; vga_color = 24'h123456; plot = 1'b1;
        tick();
        plot = 1'b0;
        n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fp_level got=%0d exp=8", fifo_level); end
        n_cmp++; if (drop_cnt !== 16'd1)  begin n_err++; $display("FAIL fp_drop got=%0d exp=1", drop_cnt); end
        n_cmp++; if (fb_we !== 1'b0)      begin n_err++; $display("FAIL fp_we_gap got=%0b exp=0", fb_we); end
        for (int c = 0; c < 60 && got < 9; c++) begin
            tick();
            if (fb_we) begin
                n_cmp++;
                if (fb_addr !== exp_addr[got] || fb_data !== exp_data[got]) begin
                    n_err++;
                    $display("FAIL drain_%0d got=%0d/%h exp=%0d/%h", got, fb_addr, fb_data, exp_addr[got], exp_data[got]);
                end
                got++;
            end
        end
        n_cmp++; if (got !== 9) begin n_err++; $display("FAIL drain_count got=%0d exp=9", got); end
        tick(); tick();
        n_cmp++; if (busy !== 1'b0 || fb_we !== 1'b0) begin n_err++; $display("FAIL drain_idle got=%0b%0b exp=00", busy, fb_we); end
    endtask

    task automatic test_reset_mid();
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vga_x = 9'(20 + i); vga_y = 8'd4; vga_color = 24'h00C000 + 24'(i); plot = 1'b1;
            tick();
        end
        plot = 1'b0;
        n_cmp++; if (fifo_level !== 4'd4 || fb_we !== 1'b1) begin n_err++; $display("FAIL rm_pre got=%0d/%0b exp=4/1", fifo_level, fb_we); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (fb_we !== 1'b0)      begin n_err++; $display("FAIL rm_we got=%0b exp=0", fb_we); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL rm_level got=%0d exp=0", fifo_level); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rm_busy got=%0b exp=0", busy); end
        n_cmp++; if ({drop_cnt, clip_cnt} !== 32'd0) begin n_err++; $display("FAIL rm_cnt got=%h exp=0", {drop_cnt, clip_cnt}); end
        fb_ready = 1'b1;
        vga_x = 9'd10; vga_y = 8'd1; vga_color = 24'hABCDEF; plot = 1'b1; tick();
        plot = 1'b0; tick(); tick();
        n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 17'd330 || fb_data !== 24'hABCDEF) begin
            n_err++; $display("FAIL rm_after got=%0b/%0d/%h exp=1/330/abcdef", fb_we, fb_addr, fb_data);
        end
        tick();
        n_cmp++; if (fb_we !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rm_done got=%0b%0b exp=00", fb_we, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_overflow();
        test_back_pressure();
        test_full_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
